// File: rtl/spi_disp_pkg.sv
// Shared constants, scan-state encoding and hex-to-7-segment table for the SPI display controller.
package spi_disp_pkg;

  localparam int NUM_DIGITS      = 4;
  localparam int REFRESH_DIV_DEF = 100000;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_e;

  // Active-low segments, bit0 = a ... bit6 = g, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [3:0] anode_of(input scan_e st);
    logic [3:0] a;
    a = 4'b1111;
    a[st] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/hex_a_7seg.sv
// Combinational nibble to active-low 7-segment pattern lookup.
module hex_a_7seg
  import spi_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/spi_display_ctrl.sv
// Captures SPI bytes into a 4-digit hex display and time-multiplexes the anodes.
// Optional leading-zero blanking of digits 3..1 with macro SPI_DISP_BLANK_ZEROS_EN.
module spi_display_ctrl
  import spi_disp_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic       clk_pi,
  input  logic       rst_n_pi,
  input  logic [7:0] dato_pi,
  input  logic       valido_pi,
  input  logic       hold_pi,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic       perdido_o
);

  localparam logic [19:0] CNT_MAX = 20'(REFRESH_DIV - 1);

  logic [15:0] disp;
  logic [19:0] cnt;
  scan_e       state;
  scan_e       state_nxt;
  logic        wrap;
  logic [3:0]  nib;
  logic [6:0]  pat;
  logic        blank;

  assign wrap = (cnt == CNT_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      DIG0: state_nxt = DIG1;
      DIG1: state_nxt = DIG2;
      DIG2: state_nxt = DIG3;
      DIG3: state_nxt = DIG0;
      default: state_nxt = DIG0;
    endcase
  end

  always_comb begin
    nib = disp[3:0];
    case (state)
      DIG0: nib = disp[3:0];
      DIG1: nib = disp[7:4];
      DIG2: nib = disp[11:8];
      DIG3: nib = disp[15:12];
      default: nib = disp[3:0];
    endcase
  end

  hex_a_7seg u_hex (
    .nib (nib),
    .seg (pat)
  );

`ifdef SPI_DISP_BLANK_ZEROS_EN
  // A digit is blank only when it and every higher digit are zero.
  always_comb begin
    blank = 1'b0;
    case (state)
      DIG1: blank = (disp[15:4] == 12'h000);
      DIG2: blank = (disp[15:8] == 8'h00);
      DIG3: blank = (disp[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      cnt   <= '0;
      state <= DIG0;
    end else if (wrap) begin
      cnt   <= '0;
      state <= state_nxt;
    end else begin
      cnt   <= cnt + 20'd1;
    end
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      disp      <= 16'h0000;
      perdido_o <= 1'b0;
    end else if (valido_pi) begin
      if (hold_pi) begin
        perdido_o <= 1'b1;
      end else begin
        disp <= {disp[7:0], dato_pi};
      end
    end
  end

  // Outputs follow the current scan state one clock later, so anode and pattern stay aligned.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      an_o  <= 4'b1111;
      seg_o <= SEG_OFF;
    end else begin
      an_o  <= anode_of(state);
      seg_o <= blank ? SEG_OFF : pat;
    end
  end

endmodule

// File: tb/tb_spi_display_ctrl.sv
// Directed and random bench for spi_display_ctrl with REFRESH_DIV=4 and a slot-level display model.
module tb_spi_display_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       vld = 1'b0;
  logic       hold = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       perd;

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [15:0] mdisp = 16'h0000;
  logic        mperd = 1'b0;
  logic [6:0]  dig_seg [4];
  logic [6:0]  hexseg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  spi_display_ctrl #(.REFRESH_DIV(4)) dut (
    .clk_pi    (clk),
    .rst_n_pi  (rst_n),
    .dato_pi   (dat),
    .valido_pi (vld),
    .hold_pi   (hold),
    .seg_o     (seg),
    .an_o      (an),
    .perdido_o (perd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, predict this edge's outputs from the model, then compare.
  task automatic tick(input logic v, input logic [7:0] d, input logic h);
    int slot;
    logic [3:0]  ea;
    logic [6:0]  es;
    logic [15:0] up;
    vld  = v;
    dat  = d;
    hold = h;
    n++;
    slot = ((n - 1) / 4) % 4;
    ea = 4'hF ^ (4'h1 << slot);
    up = mdisp >> (4 * slot);
    es = hexseg[up[3:0]];
`ifdef SPI_DISP_BLANK_ZEROS_EN
    if (slot != 0 && up == 16'h0000) es = 7'h7F;
`endif
    if (v) begin
      if (h) mperd = 1'b1;
      else   mdisp = {mdisp[7:0], d};
    end
    @(posedge clk);
    #1;
    chk("an", {12'h0, an}, {12'h0, ea});
    chk("seg", {9'h0, seg}, {9'h0, es});
    chk("perdido", {15'h0, perd}, {15'h0, mperd});
    for (int k = 0; k < 4; k++)
      if (an == (4'hF ^ (4'h1 << k))) dig_seg[k] = seg;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_seg", {9'h0, seg}, 16'h007F);
    chk("rst_perdido", {15'h0, perd}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;

    tick(1'b0, 8'h00, 1'b0);
    chk("first_an", {12'h0, an}, 16'h000E);
    chk("first_seg", {9'h0, seg}, 16'h0040);
    idle(19);

    tick(1'b1, 8'hA5, 1'b0);
    idle(3);
    tick(1'b1, 8'h3C, 1'b0);
    idle(17);
    chk("A53C_dig3", {9'h0, dig_seg[3]}, 16'h0008);
    chk("A53C_dig0", {9'h0, dig_seg[0]}, 16'h0046);

    tick(1'b1, 8'h12, 1'b0);
    tick(1'b1, 8'h12, 1'b0);
    idle(17);
    chk("b2b_dig3", {9'h0, dig_seg[3]}, 16'h0079);
    chk("b2b_dig0", {9'h0, dig_seg[0]}, 16'h0024);

    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'h07, 1'b0);
    idle(17);
    chk("z7_dig0", {9'h0, dig_seg[0]}, 16'h0078);
`ifdef SPI_DISP_BLANK_ZEROS_EN
    chk("z7_dig3", {9'h0, dig_seg[3]}, 16'h007F);
    chk("z7_dig1", {9'h0, dig_seg[1]}, 16'h007F);
`else
    chk("z7_dig3", {9'h0, dig_seg[3]}, 16'h0040);
    chk("z7_dig1", {9'h0, dig_seg[1]}, 16'h0040);
`endif

    tick(1'b1, 8'hFF, 1'b1);
    idle(17);
    chk("hold_perdido", {15'h0, perd}, 16'h0001);
    chk("hold_dig0", {9'h0, dig_seg[0]}, 16'h0078);

    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 7) == 0);

    idle(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_an", {12'h0, an}, 16'h000F);
    chk("midrst_seg", {9'h0, seg}, 16'h007F);
    chk("midrst_perdido", {15'h0, perd}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    mdisp = 16'h0000;
    mperd = 1'b0;
    idle(20);

    tick(1'b1, 8'h9E, 1'b0);
    for (int i = 0; i < 60; i++)
      tick($urandom_range(0, 2) == 0, 8'($urandom), 1'b0);
    idle(16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
